// File: rtl/beat_decimator.sv
// Boxcar decimator for the complex beat stream.
// Averages 2^DEC_LOG2 samples per output and frames the outputs into chirps.
module beat_decimator #(
  parameter int DATA_WIDTH        = 16,
  parameter int DEC_LOG2          = 2,
  parameter int SAMPLES_PER_CHIRP = 256,
  parameter int IDX_WIDTH         = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         chirp_start,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] beat_i,
  input  logic signed [DATA_WIDTH-1:0] beat_q,
  output logic signed [DATA_WIDTH-1:0] dec_i,
  output logic signed [DATA_WIDTH-1:0] dec_q,
  output logic                         valid_out,
  output logic [IDX_WIDTH-1:0]         sample_idx,
  output logic                         last_out,
  output logic                         busy,
  output logic                         frame_err
);

  localparam int ACC_W = DATA_WIDTH + DEC_LOG2;
  localparam logic [DEC_LOG2-1:0] PH_MAX = '1;
  localparam logic [IDX_WIDTH-1:0] IDX_LAST =
    IDX_WIDTH'(SAMPLES_PER_CHIRP - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state, state_d;

  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [ACC_W-1:0] acc_i_d, acc_q_d;
  logic signed [ACC_W-1:0] ext_i, ext_q;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic signed [ACC_W-1:0] sh_i, sh_q;
  logic [DEC_LOG2-1:0]     phase, phase_d;
  logic [IDX_WIDTH-1:0]    idx, idx_d;

  logic signed [DATA_WIDTH-1:0] dec_i_d, dec_q_d;
  logic [IDX_WIDTH-1:0]         sidx_d;
  logic                         valid_d, last_d, ferr_d;
  logic                         dump, is_last;

  assign ext_i = {{DEC_LOG2{beat_i[DATA_WIDTH-1]}}, beat_i};
  assign ext_q = {{DEC_LOG2{beat_q[DATA_WIDTH-1]}}, beat_q};
  assign sum_i = acc_i + ext_i;
  assign sum_q = acc_q + ext_q;
  assign sh_i  = sum_i >>> DEC_LOG2;
  assign sh_q  = sum_q >>> DEC_LOG2;

  assign dump    = (state == ACTIVE) && valid_in && (phase == PH_MAX);
  assign is_last = (idx == IDX_LAST);

  always_comb begin
    state_d = state;
    acc_i_d = acc_i;
    acc_q_d = acc_q;
    phase_d = phase;
    idx_d   = idx;
    dec_i_d = dec_i;
    dec_q_d = dec_q;
    sidx_d  = sample_idx;
    valid_d = 1'b0;
    last_d  = 1'b0;
    ferr_d  = 1'b0;
    // A restart only discards a dump that does not finish the chirp
    if (dump && (is_last || !chirp_start)) begin
      dec_i_d = sh_i[DATA_WIDTH-1:0];
      dec_q_d = sh_q[DATA_WIDTH-1:0];
      sidx_d  = idx;
      valid_d = 1'b1;
      last_d  = is_last;
      acc_i_d = '0;
      acc_q_d = '0;
      phase_d = '0;
      idx_d   = is_last ? '0 : idx + IDX_WIDTH'(1);
      if (is_last && !chirp_start) begin
        state_d = IDLE;
      end
    end else if (chirp_start) begin
      state_d = ACTIVE;
      ferr_d  = (state == ACTIVE);
      acc_i_d = valid_in ? ext_i : '0;
      acc_q_d = valid_in ? ext_q : '0;
      phase_d = DEC_LOG2'(valid_in);
      idx_d   = '0;
    end else if ((state == ACTIVE) && valid_in) begin
      acc_i_d = sum_i;
      acc_q_d = sum_q;
      phase_d = phase + DEC_LOG2'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc_i      <= '0;
      acc_q      <= '0;
      phase      <= '0;
      idx        <= '0;
      dec_i      <= '0;
      dec_q      <= '0;
      valid_out  <= 1'b0;
      sample_idx <= '0;
      last_out   <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      acc_i      <= acc_i_d;
      acc_q      <= acc_q_d;
      phase      <= phase_d;
      idx        <= idx_d;
      dec_i      <= dec_i_d;
      dec_q      <= dec_q_d;
      valid_out  <= valid_d;
      sample_idx <= sidx_d;
      last_out   <= last_d;
      busy       <= (state_d == ACTIVE);
      frame_err  <= ferr_d;
    end
  end

endmodule

// File: tb/tb_beat_decimator.sv
// Bench for beat_decimator: queue-based averaging model checked every cycle,
// plus directed vectors with literal expectations.
module tb_beat_decimator;

  localparam int DW    = 16;
  localparam int DL    = 2;
  localparam int SPC   = 4;
  localparam int IW    = 8;
  localparam int RATIO = 1 << DL;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 chirp_start;
  logic                 valid_in;
  logic signed [DW-1:0] beat_i, beat_q;
  logic signed [DW-1:0] dec_i, dec_q;
  logic                 valid_out, last_out, busy, frame_err;
  logic [IW-1:0]        sample_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int vo_cnt   = 0;
  int fe_cnt   = 0;

  beat_decimator #(
    .DATA_WIDTH(DW),
    .DEC_LOG2(DL),
    .SAMPLES_PER_CHIRP(SPC),
    .IDX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .chirp_start(chirp_start),
    .valid_in(valid_in),
    .beat_i(beat_i),
    .beat_q(beat_q),
    .dec_i(dec_i),
    .dec_q(dec_q),
    .valid_out(valid_out),
    .sample_idx(sample_idx),
    .last_out(last_out),
    .busy(busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples of the current group in queues, chirp position
  // as a plain count, averages by floor division.
  int gi[$];
  int gq[$];
  int m_n = 0;
  bit m_active = 0;
  int e_dec_i = 0, e_dec_q = 0, e_idx = 0;
  bit e_valid = 0, e_last = 0, e_busy = 0, e_ferr = 0;

  function automatic int favg(input int s);
    int r;
    r = s % RATIO;
    if (r < 0) r += RATIO;
    return (s - r) / RATIO;
  endfunction

  task automatic emit_group();
    int si, sq;
    si = 0;
    sq = 0;
    foreach (gi[k]) begin
      si += gi[k];
      sq += gq[k];
    end
    e_dec_i = favg(si);
    e_dec_q = favg(sq);
    e_idx   = m_n;
    e_last  = (m_n == SPC - 1);
    e_valid = 1;
    if (e_last) begin
      m_n = 0;
      m_active = 0;
    end else begin
      m_n++;
    end
    gi.delete();
    gq.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gi.delete();
      gq.delete();
      m_n = 0;
      m_active = 0;
      e_dec_i = 0;
      e_dec_q = 0;
      e_idx = 0;
      e_valid = 0;
      e_last = 0;
      e_busy = 0;
      e_ferr = 0;
    end else begin
      bit completes;
      e_valid = 0;
      e_last  = 0;
      e_ferr  = 0;
      completes = m_active && valid_in && (gi.size() == RATIO - 1);
      if (completes && (!chirp_start || m_n == SPC - 1)) begin
        gi.push_back(int'(beat_i));
        gq.push_back(int'(beat_q));
        emit_group();
        if (chirp_start) m_active = 1;
      end else if (chirp_start) begin
        if (m_active) e_ferr = 1;
        m_active = 1;
        m_n = 0;
        gi.delete();
        gq.delete();
        if (valid_in) begin
          gi.push_back(int'(beat_i));
          gq.push_back(int'(beat_q));
        end
      end else if (m_active && valid_in) begin
        gi.push_back(int'(beat_i));
        gq.push_back(int'(beat_q));
      end
      e_busy = m_active;
    end
  end

  always @(negedge clk) begin
    chk("cyc_dec_i", dec_i, e_dec_i);
    chk("cyc_dec_q", dec_q, e_dec_q);
    chk("cyc_valid", valid_out, e_valid);
    chk("cyc_idx", sample_idx, e_idx);
    chk("cyc_last", last_out, e_last);
    chk("cyc_busy", busy, e_busy);
    chk("cyc_ferr", frame_err, e_ferr);
    if (valid_out) vo_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic step(input bit cs, input bit v, input int i, input int q);
    chirp_start = cs;
    valid_in = v;
    beat_i = DW'(i);
    beat_q = DW'(q);
    @(negedge clk);
    #1;
  endtask

  int c0, f0;
  bit stall_v[7] = '{1, 0, 0, 1, 0, 1, 1};

  initial begin
    chirp_start = 0;
    valid_in = 0;
    beat_i = 0;
    beat_q = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dec_i", dec_i, 0);
    chk("rst_dec_q", dec_q, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;

    c0 = vo_cnt;
    repeat (4) step(0, 1, 5, 5);
    chk("idle_no_valid", vo_cnt - c0, 0);
    chk("idle_busy", busy, 0);

    c0 = vo_cnt;
    for (int k = 0; k < 16; k++) begin
      step(k == 0, 1, 4, -4);
      if (k % 4 == 3) begin
        chk("basic_valid", valid_out, 1);
        chk("basic_dec_i", dec_i, 4);
        chk("basic_dec_q", dec_q, -4);
        chk("basic_idx", sample_idx, k / 4);
        chk("basic_last", last_out, k == 15);
      end else begin
        chk("basic_gap", valid_out, 0);
      end
    end
    chk("basic_busy_fall", busy, 0);
    chk("basic_pulses", vo_cnt - c0, 4);

    step(1, 1, 1, -1);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    chk("round_i", dec_i, 0);
    chk("round_q", dec_q, -1);

    for (int k = 0; k < 4; k++) begin
      step(k == 0, 1, 32767, -32768);
      if (k == 0) chk("fs_abort_ferr", frame_err, 1);
    end
    chk("fs_valid", valid_out, 1);
    chk("fs_i", dec_i, 32767);
    chk("fs_q", dec_q, -32768);

    step(1, 0, 0, 0);
    c0 = vo_cnt;
    for (int j = 0; j < 7; j++) begin
      step(0, stall_v[j], stall_v[j] ? 8 : -77, stall_v[j] ? 8 : 77);
      chk("stall_valid", valid_out, j == 6);
    end
    chk("stall_pulses", vo_cnt - c0, 1);
    chk("stall_i", dec_i, 8);
    chk("stall_q", dec_q, 8);

    step(1, 0, 0, 0);
    repeat (8) step(0, 1, 2, 2);
    repeat (2) step(0, 1, 100, 100);
    c0 = vo_cnt;
    f0 = fe_cnt;
    for (int k = 0; k < 4; k++) begin
      step(k == 0, 1, 12, 12);
      if (k < 3) chk("abort_no_valid", valid_out, 0);
    end
    chk("abort_valid", valid_out, 1);
    chk("abort_idx", sample_idx, 0);
    chk("abort_i", dec_i, 12);
    chk("abort_q", dec_q, 12);
    chk("abort_ferr_once", fe_cnt - f0, 1);
    chk("abort_pulses", vo_cnt - c0, 1);

    step(1, 0, 0, 0);
    for (int k = 0; k < 16; k++) step(k == 15, 1, k, -k);
    chk("lastcs_valid", valid_out, 1);
    chk("lastcs_last", last_out, 1);
    chk("lastcs_idx", sample_idx, 3);
    chk("lastcs_i", dec_i, 13);
    chk("lastcs_q", dec_q, -14);
    chk("lastcs_no_ferr", frame_err, 0);
    chk("lastcs_busy", busy, 1);
    repeat (4) step(0, 1, -3, 3);
    chk("restart_idx", sample_idx, 0);
    chk("restart_i", dec_i, -3);
    chk("restart_q", dec_q, 3);
    chk("restart_last", last_out, 0);

    step(0, 1, 5, 5);
    step(0, 1, 5, 5);
    #2 rst_n = 0;
    @(negedge clk);
    #1;
    chk("mrst_dec_i", dec_i, 0);
    chk("mrst_dec_q", dec_q, 0);
    chk("mrst_idx", sample_idx, 0);
    chk("mrst_busy", busy, 0);
    rst_n = 1;
    c0 = vo_cnt;
    repeat (4) step(0, 1, 9, 9);
    chk("mrst_idle", vo_cnt - c0, 0);
    repeat (3) step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
